// File: rtl/adder_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_arbiter_pkg
// Brief    : Shared helpers and widths for the shared-adder round-robin block.
// Revision : 1.0 - initial release
// ============================================================================
package adder_rr_arbiter_pkg;

  // Requester-ID width: ceil(log2(r)), never less than one bit so that the
  // single-requester build still has a legal rsp_id port.
  function automatic int idw_of(input int r);
    return (r <= 1) ? 1 : $clog2(r);
  endfunction

  // Response record widths; the record is ordered {id, cout, sum}.
  function automatic int rsp_width(input int n, input int idw);
    return idw + 1 + n;
  endfunction

  // Default build geometry.
  localparam int DEF_N   = 4;
  localparam int DEF_R   = 4;
  localparam int DEF_IDW = idw_of(DEF_R);

endpackage : adder_rr_arbiter_pkg
`default_nettype wire

// File: rtl/Fast_Adder.sv
`default_nettype none
// ============================================================================
// Module   : Fast_Adder
// Brief    : Combinational N-bit carry-look-ahead adder, {cout,sum}=a+b+cin.
// Revision : 1.0 - initial release
// ============================================================================
module Fast_Adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;

  // Each carry is expanded as a flat sum of generate terms gated by the
  // propagate chain above them, so no carry waits on the previous one.
  always_comb begin
    logic term;
    logic pp;
    gen      = a & b;
    prop     = a ^ b;
    carry    = '0;
    carry[0] = cin;
    term     = 1'b0;
    pp       = 1'b1;
    for (int i = 0; i < N; i++) begin
      term = 1'b0;
      pp   = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (gen[j] & pp);
        pp   = pp & prop[j];
      end
      carry[i+1] = term | (cin & pp);
    end
  end

  assign sum  = prop ^ carry[N-1:0];
  assign cout = carry[N];

endmodule : Fast_Adder
`default_nettype wire

// File: rtl/adder_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_arbiter_rr_pick
// Brief    : Combinational round-robin picker; first set req bit at or above
//            ptr, wrapping from R-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module adder_rr_arbiter_rr_pick #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Walk R positions starting at ptr; the first requesting one wins.
  // Wrapping is done by subtraction so R need not be a power of two.
  always_comb begin
    int k;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < R; i++) begin
      k = int'(ptr) + i;
      if (k >= R) k = k - R;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IDW'(k);
      end
    end
  end

endmodule : adder_rr_arbiter_rr_pick
`default_nettype wire

// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_arbiter
// Brief    : R requesters share one N-bit carry-look-ahead adder through a
//            round-robin arbiter; results land in a registered, ID-tagged
//            response stage with full back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module adder_rr_arbiter
  import adder_rr_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int R = DEF_R,
  localparam int IDW = idw_of(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [R-1:0]   req_cin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_cout
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(R - 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           cout;
    logic [N-1:0]   sum;
  } rsp_t;

  rsp_t           rsp_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] ptr;

  logic [R-1:0]   grant;
  logic [IDW-1:0] g;
  logic           any;
  logic           can_load;
  logic           accept;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           op_cin;
  logic [N-1:0]   add_sum;
  logic           add_cout;
  logic [IDW-1:0] ptr_next;

  adder_rr_arbiter_rr_pick #(
    .R   (R),
    .IDW (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (g),
    .any   (any)
  );

  // The response slot can take a new result when empty or being drained now.
  assign can_load  = !rsp_valid_q || rsp_ready;
  assign accept    = !rst && can_load && any;
  assign req_ready = accept ? grant : '0;

  // Operand mux steered by the winning index feeds the single adder.
  assign op_a   = req_a[int'(g)*N +: N];
  assign op_b   = req_b[int'(g)*N +: N];
  assign op_cin = req_cin[g];

  Fast_Adder #(
    .N (N)
  ) u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Priority moves to the requester just after the winner.
  assign ptr_next = (g == LAST_ID) ? '0 : g + IDW'(1);

  // Response register and priority pointer; a drain without a new accept
  // clears only the valid flag so the data fields keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      ptr         <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q.id    <= g;
      rsp_q.cout  <= add_cout;
      rsp_q.sum   <= add_sum;
      ptr         <= ptr_next;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_sum   = rsp_q.sum;

endmodule : adder_rr_arbiter
`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_rr_arbiter
// Brief    : Directed self-checking bench for adder_rr_arbiter (N=4, R=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_sum;
  logic        rsp_cout;

  // Hand-computed results per requester for the operands loaded below.
  logic [3:0]  exp_sum  [4];
  logic        exp_cout [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_rr_arbiter #(
    .N (4),
    .R (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_rsp(input string tag, input int id);
    check_eq({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, ".id"},    32'(rsp_id),    32'(id));
    check_eq({tag, ".sum"},   32'(rsp_sum),   32'(exp_sum[id]));
    check_eq({tag, ".cout"},  32'(rsp_cout),  32'(exp_cout[id]));
  endtask

  initial begin
    // Operands: r0 1+2+0=3; r1 7+9+0=16 -> 0,c1; r2 9+8+1=18 -> 2,c1; r3 5+5+1=11 -> B,c0
    req_a   = {4'h5, 4'h9, 4'h7, 4'h1};
    req_b   = {4'h5, 4'h8, 4'h9, 4'h2};
    req_cin = 4'b1100;
    exp_sum[0] = 4'h3; exp_cout[0] = 1'b0;
    exp_sum[1] = 4'h0; exp_cout[1] = 1'b1;
    exp_sum[2] = 4'h2; exp_cout[2] = 1'b1;
    exp_sum[3] = 4'hB; exp_cout[3] = 1'b0;

    // 1. Reset with traffic present.
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    settle();
    check_eq("rst_c0.ready", 32'(req_ready), 32'h0);
    step();
    check_eq("rst_c1.ready", 32'(req_ready), 32'h0);
    check_eq("rst_c1.valid", 32'(rsp_valid), 32'h0);
    step();
    check_eq("rst_c2.valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    settle();
    check_eq("rel.ready", 32'(req_ready), 32'b0001);

    // 3. Full contention: ids 0,1,2,3,0,1 back to back.
    for (int j = 0; j < 6; j++) begin
      check_eq("cont.ready", 32'(req_ready), 32'(1 << (j % 4)));
      step();
      check_rsp("cont", j % 4);
    end
    req_valid = 4'b0000;
    settle();
    check_eq("idle.ready", 32'(req_ready), 32'h0);
    step();
    check_eq("drain.valid", 32'(rsp_valid), 32'h0);
    check_eq("drain.sum",   32'(rsp_sum),   32'h0);
    check_eq("drain.cout",  32'(rsp_cout),  32'h1);
    check_eq("drain.id",    32'(rsp_id),    32'h1);

    // 2. Single requests (ptr=2 now).
    req_valid = 4'b0100;
    settle();
    check_eq("single2.ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    check_rsp("single2", 2);
    req_a[3:0] = 4'hF; req_b[3:0] = 4'hF; req_cin[0] = 1'b1;
    exp_sum[0] = 4'hF; exp_cout[0] = 1'b1;
    req_valid = 4'b0001;
    settle();
    check_eq("single0.ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    check_rsp("single0", 0);

    // 4. Back-pressure with 0110 waiting (ptr=1).
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("stall.ready", 32'(req_ready), 32'h0);
      check_rsp("stall", 0);
      step();
    end
    rsp_ready = 1'b1;
    settle();
    check_eq("unstall.ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    check_rsp("unstall", 1);

    // 5. Pointer wrap and skip (ptr=2).
    req_valid = 4'b0100;
    settle();
    check_eq("wrap2.ready", 32'(req_ready), 32'b0100);
    step();
    check_rsp("wrap2", 2);
    req_valid = 4'b0011;
    settle();
    check_eq("wrap0.ready", 32'(req_ready), 32'b0001);
    step();
    check_rsp("wrap0", 0);
    check_eq("wrap1.ready", 32'(req_ready), 32'b0010);
    step();
    check_rsp("wrap1", 1);
    req_valid = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      int e;
      e = (j % 2 == 0) ? 3 : 1;
      settle();
      check_eq("skip.ready", 32'(req_ready), 32'(1 << e));
      step();
      check_rsp("skip", e);
    end

    // 6. Reset during stall.
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    settle();
    step();
    check_rsp("prerst", 1);
    rst       = 1'b1;
    req_valid = 4'b1111;
    settle();
    check_eq("rststall.ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    settle();
    check_eq("postrst.valid", 32'(rsp_valid), 32'h0);
    check_eq("postrst.id",    32'(rsp_id),    32'h0);
    check_eq("postrst.sum",   32'(rsp_sum),   32'h0);
    check_eq("postrst.ready", 32'(req_ready), 32'b0001);
    rsp_ready = 1'b1;
    step();
    req_valid = 4'b0000;
    check_rsp("postrst", 0);
    step();
    check_eq("final.valid", 32'(rsp_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_adder_rr_arbiter
`default_nettype wire

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one combinational N-bit carry-look-ahead adder (existing Fast_Adder) between R independent requesters.
- Each requester presents operands under a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle.
- The sum/carry is captured in a registered response stage tagged with the requester ID, with full back-pressure.

Parameters:
- N, 4, adder operand width in bits.
- R, 4, number of requesters (>=1, not required to be a power of two).
- IDW, $clog2(R) (min 1), width of requester ID; derived, not overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  R  per-requester request valid.
- req_ready  out  R  per-requester grant/accept; at most one bit high.
- req_a  in  R*N  operand A, requester k at bits [k*N +: N].
- req_b  in  R*N  operand B, same packing.
- req_cin  in  R  carry-in per requester.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  downstream accepts response.
- rsp_id  out  IDW  index of requester that produced the response.
- rsp_sum  out  N  registered sum.
- rsp_cout  out  1  registered carry-out.

Behaviour:
- Reset is synchronous, active-high. While rst=1:
  - req_ready is forced to 0.
  - On the clock edge, rsp_valid, rsp_sum, rsp_cout, rsp_id and the priority pointer ptr all go to 0.
- Reset mid-stall or mid-transfer discards the held response; no request is accepted in a reset cycle.
- Accept condition: `can_load = !rsp_valid || rsp_ready`.
- Arbitration is combinational, round-robin:
  - Search req_valid from index ptr upward, wrapping from R-1 to 0.
  - The first valid index is g.
  - If can_load and any req_valid: req_ready[g]=1, all other bits 0. Otherwise req_ready=0.
- Handshake:
  - A transfer on requester k occurs when req_valid[k] && req_ready[k].
  - A requester holds req_valid and its operands stable until accepted, and must not gate req_valid on req_ready.
  - A response transfer occurs when rsp_valid && rsp_ready.
- Datapath: a single shared adder. Its operand mux is selected by g and computes `{cout,sum} = a + b + cin`, modulo 2^N with carry out.
- On a request transfer (next edge):
  - rsp_sum/rsp_cout get the adder outputs.
  - rsp_id gets g, and rsp_valid gets 1.
  - ptr gets g+1, wrapping R-1 to 0.
- Latency is one cycle from accept to rsp_valid.
- Throughput: one result per cycle when rsp_ready stays high. A simultaneous response drain and new accept is required, with no bubble.
- Response drained with no new accept: rsp_valid goes to 0 and the data fields hold their last values.
- Stall (rsp_valid && !rsp_ready): all response fields stay stable, req_ready=0, ptr unchanged.
- No valid requests: ptr unchanged, rsp_valid follows the drain rule.
- Fairness: a continuously valid requester is granted within R accepts.
- R=1: ptr stays 0, rsp_id=0, and the block degenerates to a registered adder with handshake.

Decomposition:
- Shared package: the IDW derivation function (clog2 with minimum 1) and the response struct/field widths {id, cout, sum}.
- One natural sub-module, rr_pick: a parameterised combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded index g, any.
- The adder is an instance of the existing Fast_Adder with N passed through.

Test Plan:
1. Reset with traffic: rst=1 for 2 cycles while req_valid=4'b1111 -> req_ready=0 and rsp_valid=0 throughout. First cycle after release, req_ready=4'b0001.
2. Single request, rsp_ready=1: requester 2 with a=4'h9, b=4'h8, cin=1 -> next cycle rsp_valid=1, rsp_sum=4'h2, rsp_cout=1, rsp_id=2. Then requester 0 with a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1.
3. Full contention: all four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
4. Back-pressure: a response is pending and rsp_ready=0 for 3 cycles with req_valid=4'b0110 -> req_ready=0 and rsp fields stable for all 3 cycles. In the cycle rsp_ready returns to 1, req_ready[1]=1 and the next result appears one cycle later.
5. Pointer wrap/skip: after a grant to requester 2 (ptr=3), assert only req_valid=4'b0011 -> grants go 0 then 1. With only 4'b1010 held -> grants alternate 3,1,3,1.
6. Reset during stall: response pending with rsp_ready=0, then assert rst for 1 cycle -> rsp_valid=0 next cycle. With 4'b1111 valid afterwards, the first grant is requester 0.
